// File: rtl/axi4l_pkg.sv
// Shared types for the AXI4-Lite register file: response codes,
// register modes, channel FSM states and a byte-lane mask helper.
package axi4l_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        MODE_RW,
        MODE_RO,
        MODE_W1C
    } reg_mode_t;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    // Expand up to 8 byte strobes into a 64-bit bit mask.
    function automatic logic [63:0] lane_mask(input logic [7:0] strb);
        logic [63:0] m;
        m = '0;
        for (int b = 0; b < 8; b++) begin
            m[b*8 +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/axi4l_reg_cell.sv
// One register of the file. RW: masked replace; W1C: masked clear
// plus hw_set_i (set wins); RO: pure mirror of hw_d_i, no storage.
// Ports: clk_i/rst_i, we_i/wdata_i/wmask_i write, hw_set_i/hw_d_i hw side, q_o value.
module axi4l_reg_cell
    import axi4l_pkg::*;
#(
    parameter int              DW        = 32,
    parameter reg_mode_t       MODE      = MODE_RW,
    parameter logic [DW-1:0]   RESET_VAL = '0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [DW-1:0] wmask_i,
    input  logic [DW-1:0] hw_set_i,
    input  logic [DW-1:0] hw_d_i,
    output logic [DW-1:0] q_o
);

    // Not every mode consumes every input.
    logic unused_cell;
    assign unused_cell = ^{clk_i, rst_i, we_i, wdata_i,
                           wmask_i, hw_set_i, hw_d_i};

    if (MODE == MODE_RO) begin : g_ro
        assign q_o = hw_d_i;
    end else begin : g_store
        logic [DW-1:0] q_q;
        logic [DW-1:0] q_d;

        always_comb begin
            q_d = q_q;
            if (MODE == MODE_W1C) begin
                if (we_i) begin
                    q_d = q_q & ~(wdata_i & wmask_i);
                end
                // Applied after the clear so a colliding set wins.
                q_d = q_d | hw_set_i;
            end else if (we_i) begin
                q_d = (q_q & ~wmask_i) | (wdata_i & wmask_i);
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                q_q <= RESET_VAL;
            end else begin
                q_q <= q_d;
            end
        end

        assign q_o = q_q;
    end

endmodule

// File: rtl/axi4l_regfile.sv
// AXI4-Lite slave register file with RW/RO/W1C registers, independent
// AW/W capture, byte strobes, SLVERR decode and hw set/load ports.
// Ports: aclk/areset, AXI4-Lite AW/W/B/AR/R, reg_q, hw_d, hw_set, wr_pulse.
module axi4l_regfile
    import axi4l_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
    parameter logic [NUM_REGS-1:0] W1C_MASK = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic                           awprot,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic                           arvalid,
    output logic                           arready,
    input  logic                           arprot,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_d,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int DW  = DATA_WIDTH;
    localparam int SW  = DATA_WIDTH / 8;
    localparam int LSB = $clog2(SW);
    localparam int IW  = ADDR_WIDTH - LSB;

    // ---------------- write channel ----------------
    wr_state_t        w_state_q, w_state_d;
    logic             aw_held_q, aw_held_d;
    logic             w_held_q, w_held_d;
    logic [IW-1:0]    awidx_q, awidx_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [SW-1:0]    wstrb_q, wstrb_d;
    resp_t            bresp_q, bresp_d;
    logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

    logic             aw_hs, w_hs, wr_go, w_in_range;
    logic [IW-1:0]    w_idx;
    logic [DW-1:0]    w_data;
    logic [SW-1:0]    w_strb;
    logic [63:0]      mask64;
    logic [DW-1:0]    w_mask;
    logic [NUM_REGS-1:0] wr_sel;

    // Readies depend only on state (and reset), never on valids.
    assign awready = (w_state_q == W_IDLE) && !aw_held_q && !areset;
    assign wready  = (w_state_q == W_IDLE) && !w_held_q && !areset;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    // Payload for the write: live bus if it handshakes now, else held copy.
    assign w_idx  = aw_hs ? awaddr[ADDR_WIDTH-1:LSB] : awidx_q;
    assign w_data = w_hs ? wdata : wdata_q;
    assign w_strb = w_hs ? wstrb : wstrb_q;
    assign mask64 = lane_mask(8'(w_strb));
    assign w_mask = mask64[DW-1:0];

    assign wr_go = (w_state_q == W_IDLE)
                && (aw_held_q || aw_hs)
                && (w_held_q || w_hs);
    assign w_in_range = 32'(w_idx) < NUM_REGS;

    always_comb begin
        w_state_d  = w_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awidx_d    = awidx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awidx_d   = awaddr[ADDR_WIDTH-1:LSB];
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = wdata;
                    wstrb_d  = wstrb;
                end
                if (wr_go) begin
                    w_state_d  = W_RESP;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    bresp_d    = w_in_range ? OKAY : SLVERR;
                    wr_pulse_d = wr_sel;
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_d = W_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state_q  <= W_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awidx_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= OKAY;
            wr_pulse_q <= '0;
        end else begin
            w_state_q  <= w_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awidx_q    <= awidx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    assign bvalid   = (w_state_q == W_RESP);
    assign bresp    = bresp_q;
    assign wr_pulse = wr_pulse_q;

    // ---------------- register cells ----------------
    logic [DW-1:0] regs [NUM_REGS];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        localparam reg_mode_t MODE = RO_MASK[i]  ? MODE_RO :
                                     W1C_MASK[i] ? MODE_W1C : MODE_RW;

        // Index match implies in-range; RO slots never take a write.
        assign wr_sel[i] = wr_go && (32'(w_idx) == i) && !RO_MASK[i];

        axi4l_reg_cell #(
            .DW        (DW),
            .MODE      (MODE),
            .RESET_VAL (RESET_VAL[i*DW +: DW])
        ) u_cell (
            .clk_i    (aclk),
            .rst_i    (areset),
            .we_i     (wr_sel[i]),
            .wdata_i  (w_data),
            .wmask_i  (w_mask),
            .hw_set_i (hw_set[i*DW +: DW]),
            .hw_d_i   (hw_d[i*DW +: DW]),
            .q_o      (regs[i])
        );

        assign reg_q[i*DW +: DW] = regs[i];
    end

    // ---------------- read channel ----------------
    rd_state_t     r_state_q, r_state_d;
    logic [DW-1:0] rdata_q, rdata_d;
    resp_t         rresp_q, rresp_d;
    logic          ar_hs, r_in_range;
    logic [IW-1:0] r_idx;
    logic [DW-1:0] rd_val;

    assign arready    = (r_state_q == R_IDLE) && !areset;
    assign ar_hs      = arvalid && arready;
    assign r_idx      = araddr[ADDR_WIDTH-1:LSB];
    assign r_in_range = 32'(r_idx) < NUM_REGS;

    // RO cells already present hw_d on their output.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(r_idx) == i) begin
                rd_val = regs[i];
            end
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_DATA;
                    rdata_d   = r_in_range ? rd_val : '0;
                    rresp_d   = r_in_range ? OKAY : SLVERR;
                end
            end
            R_DATA: begin
                if (rready) begin
                    r_state_d = R_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state_q <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
        end else begin
            r_state_q <= r_state_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign rvalid = (r_state_q == R_DATA);
    assign rdata  = rdata_q;
    assign rresp  = rresp_q;

    logic unused_ok;
    assign unused_ok = ^{awprot, arprot, awaddr[LSB-1:0],
                         araddr[LSB-1:0], mask64};

endmodule

// File: tb/tb_axi4l_regfile.sv
// Directed plus randomized bench for axi4l_regfile against a
// behavioural register model kept in plain arrays.
module tb_axi4l_regfile;

    localparam int NR = 16;
    localparam int DW = 32;
    localparam int AW = 12;
    localparam logic [NR-1:0] RO_M  = 16'h0101;
    localparam logic [NR-1:0] W1C_M = 16'h0028;
    localparam logic [NR*DW-1:0] RV =
        (512'hCAFEF00D << 192) | (512'hFFFF0000 << 160);

    logic aclk = 1'b0;
    logic areset;
    logic [AW-1:0] awaddr, araddr;
    logic awvalid, awready, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [3:0] wstrb;
    logic [1:0] bresp, rresp;
    logic [NR*DW-1:0] reg_q, hw_d, hw_set;
    logic [NR-1:0] wr_pulse;

    logic [31:0] hwd [NR];
    logic [31:0] hws [NR];
    logic [31:0] mdl [NR];
    int total = 0;
    int bad = 0;

    always #5 aclk = ~aclk;

    always_comb begin
        hw_d   = '0;
        hw_set = '0;
        for (int i = 0; i < NR; i++) begin
            hw_d[i*DW +: DW]   = hwd[i];
            hw_set[i*DW +: DW] = hws[i];
        end
    end

    axi4l_regfile #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .RO_MASK    (RO_M),
        .W1C_MASK   (W1C_M),
        .RESET_VAL  (RV)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .awaddr   (awaddr),
        .awvalid  (awvalid),
        .awready  (awready),
        .awprot   (1'b0),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wvalid   (wvalid),
        .wready   (wready),
        .bresp    (bresp),
        .bvalid   (bvalid),
        .bready   (bready),
        .araddr   (araddr),
        .arvalid  (arvalid),
        .arready  (arready),
        .arprot   (1'b0),
        .rdata    (rdata),
        .rresp    (rresp),
        .rvalid   (rvalid),
        .rready   (rready),
        .reg_q    (reg_q),
        .hw_d     (hw_d),
        .hw_set   (hw_set),
        .wr_pulse (wr_pulse)
    );

    task automatic check(input string tag, input logic [511:0] obs,
                         input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic void mdl_reset();
        for (int i = 0; i < NR; i++) mdl[i] = RV[i*DW +: DW];
    endfunction

    function automatic logic [NR*DW-1:0] exp_flat();
        logic [NR*DW-1:0] v;
        v = '0;
        for (int i = 0; i < NR; i++)
            v[i*DW +: DW] = RO_M[i] ? hwd[i] : mdl[i];
        return v;
    endfunction

    function automatic void mdl_write(input logic [AW-1:0] a,
                                      input logic [31:0] d,
                                      input logic [3:0] s,
                                      output logic [1:0] resp,
                                      output logic [NR-1:0] pulse);
        int idx;
        idx   = int'(a) / 4;
        resp  = 2'b00;
        pulse = '0;
        if (idx >= NR) begin
            resp = 2'b10;
            return;
        end
        if (RO_M[idx]) return;
        pulse[idx] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) begin
                if (W1C_M[idx]) mdl[idx][b*8 +: 8] &= ~d[b*8 +: 8];
                else            mdl[idx][b*8 +: 8]  =  d[b*8 +: 8];
            end
        end
    endfunction

    task automatic write_txn(input logic [AW-1:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int awd,
                             input int wd, input logic [31:0] set3);
        logic [1:0] er;
        logic [NR-1:0] ep;
        int n1, n2;
        n1 = 0;
        n2 = 0;
        hws[3] = set3;
        fork
            begin
                repeat (awd) tick();
                awaddr  = a;
                awvalid = 1'b1;
                while (!awready && n1 < 20) begin tick(); n1++; end
                tick();
                awvalid = 1'b0;
            end
            begin
                repeat (wd) tick();
                wdata  = d;
                wstrb  = s;
                wvalid = 1'b1;
                while (!wready && n2 < 20) begin tick(); n2++; end
                tick();
                wvalid = 1'b0;
            end
        join
        hws[3] = '0;
        check("aw_wait", n1 < 20, 1);
        check("w_wait", n2 < 20, 1);
        mdl_write(a, d, s, er, ep);
        mdl[3] |= set3;
        check("b_latency", bvalid, 1);
        check("bresp", bresp, er);
        check("wr_pulse", wr_pulse, ep);
        check("reg_q_wr", reg_q, exp_flat());
        tick();
        check("b_done", bvalid, 0);
        check("pulse_1cyc", wr_pulse, 0);
    endtask

    task automatic read_txn(input logic [AW-1:0] a);
        logic [31:0] ed;
        logic [1:0] er;
        int idx, n;
        idx = int'(a) / 4;
        n = 0;
        if (idx >= NR) begin
            ed = '0;
            er = 2'b10;
        end else begin
            ed = RO_M[idx] ? hwd[idx] : mdl[idx];
            er = 2'b00;
        end
        araddr  = a;
        arvalid = 1'b1;
        while (!arready && n < 20) begin tick(); n++; end
        tick();
        arvalid = 1'b0;
        check("ar_wait", n < 20, 1);
        check("r_latency", rvalid, 1);
        check("rdata", rdata, ed);
        check("rresp", rresp, er);
        tick();
        check("r_done", rvalid, 0);
    endtask

    task automatic hw_pulse();
        hwd[0] = $urandom;
        hwd[8] = $urandom;
        hws[1] = $urandom;
        hws[3] = $urandom;
        hws[5] = $urandom;
        tick();
        mdl[3] |= hws[3];
        mdl[5] |= hws[5];
        hws[1] = '0;
        hws[3] = '0;
        hws[5] = '0;
        check("reg_q_hw", reg_q, exp_flat());
    endtask

    initial begin
        logic [1:0] er;
        logic [NR-1:0] ep;
        int op;
        areset  = 1'b1;
        awaddr  = '0;
        araddr  = '0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        arvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        bready  = 1'b1;
        rready  = 1'b1;
        for (int i = 0; i < NR; i++) begin
            hwd[i] = '0;
            hws[i] = '0;
        end
        hwd[8] = 32'h8888_0008;
        mdl_reset();

        repeat (2) tick();
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_arready", arready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_bresp", bresp, 0);
        check("rst_rresp", rresp, 0);
        check("rst_rdata", rdata, 0);
        check("rst_pulse", wr_pulse, 0);
        check("rst_regs", reg_q, exp_flat());
        areset = 1'b0;
        #1;
        check("rel_awready", awready, 1);
        check("rel_wready", wready, 1);
        check("rel_arready", arready, 1);
        tick();

        // Same-cycle AW/W
        write_txn(12'h004, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0);
        check("reg1_val", reg_q[1*DW +: DW], 32'hDEADBEEF);

        // W three cycles ahead of AW, partial strobe
        wdata  = 32'h12345678;
        wstrb  = 4'h3;
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("w_held_rdy0", wready, 0);
        repeat (2) begin
            tick();
            check("w_held_rdy", wready, 0);
        end
        awaddr  = 12'h008;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        mdl_write(12'h008, 32'h12345678, 4'h3, er, ep);
        check("wfirst_bvalid", bvalid, 1);
        check("wfirst_wready", wready, 0);
        check("wfirst_pulse", wr_pulse, ep);
        check("reg2_val", reg_q[2*DW +: DW], 32'h00005678);
        tick();
        check("wfirst_bdone", bvalid, 0);
        check("wfirst_wrdy", wready, 1);

        // W1C: hw set, then clear, then colliding set/clear
        hws[3] = 32'h000000F0;
        tick();
        hws[3] = '0;
        mdl[3] |= 32'h000000F0;
        write_txn(12'h00C, 32'h30, 4'hF, 0, 0, 32'h0);
        check("w1c_clear", reg_q[3*DW +: DW], 32'hC0);
        read_txn(12'h00C);
        write_txn(12'h00C, 32'h10, 4'hF, 0, 0, 32'h10);
        check("w1c_setwins", reg_q[3*DW +: DW], 32'hD0);
        read_txn(12'h00C);

        // RO register 0
        hwd[0] = 32'hA5A5A5A5;
        read_txn(12'h000);
        write_txn(12'h000, 32'hFFFFFFFF, 4'hF, 1, 0, 32'h0);
        check("ro_unchanged", reg_q[0 +: DW], 32'hA5A5A5A5);

        // Out of range
        write_txn(12'h040, 32'h11223344, 4'hF, 0, 2, 32'h0);
        read_txn(12'h040);
        read_txn(12'h018);

        // B back-pressure
        bready  = 1'b0;
        awaddr  = 12'h018;
        wdata   = 32'h0BADF00D;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        mdl_write(12'h018, 32'h0BADF00D, 4'hF, er, ep);
        repeat (5) begin
            check("bp_bvalid", bvalid, 1);
            check("bp_awready", awready, 0);
            check("bp_bresp", bresp, 0);
            tick();
        end
        bready = 1'b1;
        tick();
        check("bp_release", bvalid, 0);
        check("bp_reg", reg_q, exp_flat());

        // Randomized mix
        for (int k = 0; k < 80; k++) begin
            op = $urandom_range(0, 3);
            if (op < 2)
                write_txn(12'($urandom_range(0, 'h4F)), $urandom,
                          4'($urandom_range(0, 15)),
                          $urandom_range(0, 3), $urandom_range(0, 3),
                          32'h0);
            else if (op == 2)
                read_txn(12'($urandom_range(0, 'h4F)));
            else
                hw_pulse();
        end

        // Reset while a read response is pending
        rready  = 1'b0;
        araddr  = 12'h004;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("pend_rvalid", rvalid, 1);
        areset = 1'b1;
        #1;
        mdl_reset();
        check("abort_rvalid", rvalid, 0);
        check("abort_rdata", rdata, 0);
        check("abort_regs", reg_q, exp_flat());
        rready = 1'b1;
        tick();
        areset = 1'b0;
        tick();
        read_txn(12'h004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4l_regfile.md
# axi4l_regfile

Parametrised AXI4-Lite slave register file: NUM_REGS registers of DATA_WIDTH bits, each RW, RO or W1C (write-one-to-clear). Handles independent AW/W arrival, byte strobes, SLVERR on out-of-range addresses, and hardware-side set/load inputs. It sits behind an `axi4l_if` instance as the standard control/status block for datapath modules.

## Interface

Parameters:
- ADDR_WIDTH, 12: AXI address width.
- DATA_WIDTH, 32: data width; must be 32 or 64.
- NUM_REGS, 16: number of registers, 1..2**(ADDR_WIDTH-log2(DATA_WIDTH/8)).
- RO_MASK, '0: NUM_REGS bits; bit i = 1 makes register i read-only.
- W1C_MASK, '0: NUM_REGS bits; bit i = 1 makes register i W1C. RO_MASK & W1C_MASK must be 0.
- RESET_VAL, '0: NUM_REGS*DATA_WIDTH reset values for RW/W1C registers.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- awaddr/awvalid/awready/awprot, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready/arprot, rdata/rresp/rvalid/rready: AXI4-Lite slave with `axi4l_if` widths. awprot and arprot are 1 bit and ignored.
- reg_q  out  NUM_REGS*DATA_WIDTH  current register values. RO slots mirror hw_d.
- hw_d  in  NUM_REGS*DATA_WIDTH  RO register source, sampled at read.
- hw_set  in  NUM_REGS*DATA_WIDTH  W1C bit-set pulses. Ignored for non-W1C registers.
- wr_pulse  out  NUM_REGS  one-cycle pulse when register i accepts a write with OKAY.

## Operation

- Decode: idx = addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]. The low byte-offset bits are ignored. idx >= NUM_REGS gives resp 2'b10 (SLVERR); any other index gives 2'b00.
- Write FSM, states W_IDLE and W_RESP:
  - W_IDLE: awready = !aw_held and wready = !w_held. Each handshake latches its payload and sets its held flag.
  - AW and W may complete in the same cycle or in either order, any number of cycles apart.
  - When both are held, or complete on the current edge, the write is applied on that edge. The FSM then enters W_RESP with bvalid=1 and both held flags cleared.
  - W_RESP: awready=wready=0. bvalid is held until bready, then the FSM returns to W_IDLE.
- Write effect, byte lane b enabled by wstrb[b]:
  - RW register: the lane is replaced.
  - W1C register: reg &= ~wdata on enabled lanes.
  - RO register, or SLVERR: no change.
  - wr_pulse[idx] pulses only for an in-range, non-RO write.
- W1C set: reg |= hw_set every cycle. If a set and a clear hit the same bit on the same edge, the set wins.
- Read FSM, states R_IDLE and R_DATA:
  - R_IDLE: arready=1. On handshake, rdata and rresp are registered and the FSM enters R_DATA with rvalid=1.
  - rdata source: reg_q[idx], or hw_d[idx] for RO registers, or 0 on SLVERR.
  - R_DATA: arready=0, and rdata/rresp are held stable until rready, then the FSM returns to R_IDLE.
- Read and write run independently. A read and a write to the same register completing on the same edge: the read returns the pre-write value.

## Timing

- Reset values: awready=wready=arready=0 during reset and 1 in the first cycle after release. bvalid=rvalid=0, bresp=rresp=0, rdata=0, wr_pulse=0. Registers take RESET_VAL.
- Write latency: bvalid and the register update occur 1 cycle after the later of the AW/W handshakes. Throughput is one write per 2 cycles with bready tied high.
- Read latency: rvalid 1 cycle after the AR handshake. Throughput is one read per 2 cycles.
- Handshake rule: valid→ready paths are combinational from state only. There is no combinational path from awvalid, wvalid or arvalid to any ready.
- Reset mid-transaction: reset asserted with bvalid or rvalid pending aborts the transaction. Outputs take reset values immediately and no write is applied.

## Structure

- Package `axi4l_pkg`:
  - resp_t enum (OKAY=2'b00, SLVERR=2'b10).
  - reg_mode_t enum (RW, RO, W1C).
  - wr_state_t and rd_state_t.
  - a byte-lane mask function.
- Sub-module `axi4l_reg_cell`: one register with a mode parameter, strobe-masked write, W1C set/clear and reset value. Instantiated NUM_REGS times in a generate loop.

## Test plan

- AW and W in the same cycle: addr 0x4, data 0xDEADBEEF, strb 0xF → bvalid 1 cycle later with OKAY, reg_q[1]=0xDEADBEEF, wr_pulse[1] a single pulse.
- W 3 cycles before AW: addr 0x8, wstrb 0x3, data 0x12345678 over reset 0 → reg 2 = 0x00005678. wready=0 from the W handshake until bvalid clears.
- W1C register 3, hw_set=0xF0: then write 0x30 → reads 0xC0. Then a same-cycle hw_set=0x10 plus a write of 0x10 → bit 4 stays 1.
- Read of RO register 0 with hw_d[0]=0xA5A5A5A5 → rdata 0xA5A5A5A5 OKAY. A write to it returns OKAY, leaves it unchanged, and gives no wr_pulse.
- NUM_REGS=16, access to addr 0x40: write → bresp 2'b10 and no register change. Read → rresp 2'b10, rdata 0.
- Back-pressure: bready held low 5 cycles → bvalid stable and awready=0 throughout. Reset asserted while rvalid=1 → rvalid=0 immediately.
